change_dispenser: RTL and testbench

- Return path of the vending machine: the accumulator collects inserted currency; this block pays change back out, one coin at a time.
- Accepts a change amount from the transaction controller.
- Decomposes the amount greedily into fixed coin denominations, limited by a per-denomination coin inventory.
- Presents each coin to the coin-ejector mechanism over a valid/ready handshake.
- Reports completion, or a shortfall when the inventory cannot cover the amount.

---
 rtl/change_dispenser_if.sv | 23 ++
 rtl/change_dispenser.sv | 163 ++++++++++++++++
 tb/tb_change_dispenser.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Coin ejector handshake: the dispenser offers one coin at a time, the ejector
// accepts it by raising coin_ready while coin_valid is high.
interface change_dispenser_if #(
  parameter int CURRENCY_WIDTH = 7
) ();

  logic [CURRENCY_WIDTH-1:0] coin_value;
  logic                      coin_valid;
  logic                      coin_ready;

  modport master (
    output coin_value,
    output coin_valid,
    input  coin_ready
  );

  modport slave (
    input  coin_value,
    input  coin_valid,
    output coin_ready
  );

endinterface

// File: rtl/change_dispenser.sv
// Vending machine change return: greedily breaks a change amount into coins,
// limited by per-denomination inventory, and ejects them one at a time.
module change_dispenser #(
  parameter int CURRENCY_WIDTH = 7,
  parameter int DENOM_0        = 25,
  parameter int DENOM_1        = 10,
  parameter int DENOM_2        = 5,
  parameter int DENOM_3        = 1,
  parameter int COUNT_WIDTH    = 4,
  parameter int INIT_COUNT     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CURRENCY_WIDTH-1:0] change_value,
  input  logic                      change_valid,
  input  logic                      refill,
  change_dispenser_if.master        coin,
  output logic                      busy,
  output logic                      change_done,
  output logic                      change_short,
  output logic [CURRENCY_WIDTH-1:0] remaining,
  output logic [COUNT_WIDTH-1:0]    coin_count_0,
  output logic [COUNT_WIDTH-1:0]    coin_count_1,
  output logic [COUNT_WIDTH-1:0]    coin_count_2,
  output logic [COUNT_WIDTH-1:0]    coin_count_3
);

  localparam logic [CURRENCY_WIDTH-1:0] D0 = CURRENCY_WIDTH'(DENOM_0);
  localparam logic [CURRENCY_WIDTH-1:0] D1 = CURRENCY_WIDTH'(DENOM_1);
  localparam logic [CURRENCY_WIDTH-1:0] D2 = CURRENCY_WIDTH'(DENOM_2);
  localparam logic [CURRENCY_WIDTH-1:0] D3 = CURRENCY_WIDTH'(DENOM_3);
  localparam logic [COUNT_WIDTH-1:0]    INIT = COUNT_WIDTH'(INIT_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PRESENT,
    DONE,
    SHORT
  } state_t;

  state_t state, state_next;

  logic [CURRENCY_WIDTH-1:0] coin_value_q;
  logic [1:0]                sel_q;
  logic [COUNT_WIDTH-1:0]    coin_count [4];

  logic                      pick_found;
  logic [1:0]                pick_idx;
  logic [CURRENCY_WIDTH-1:0] pick_value;

  // Largest denomination that both fits the remaining amount and is in stock.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    pick_value = '0;
    if (D0 <= remaining && coin_count[0] != '0) begin
      pick_found = 1'b1;
      pick_idx   = 2'd0;
      pick_value = D0;
    end else if (D1 <= remaining && coin_count[1] != '0) begin
      pick_found = 1'b1;
      pick_idx   = 2'd1;
      pick_value = D1;
    end else if (D2 <= remaining && coin_count[2] != '0) begin
      pick_found = 1'b1;
      pick_idx   = 2'd2;
      pick_value = D2;
    end else if (D3 <= remaining && coin_count[3] != '0) begin
      pick_found = 1'b1;
      pick_idx   = 2'd3;
      pick_value = D3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    busy              = (state != IDLE);
    change_done       = (state == DONE);
    change_short      = (state == SHORT);
    coin.coin_valid   = (state == PRESENT);
    coin.coin_value   = coin_value_q;
    case (state)
      IDLE: begin
        if (change_valid) begin
          state_next = SELECT;
        end
      end
      SELECT: begin
        if (remaining == '0) begin
          state_next = DONE;
        end else if (pick_found) begin
          state_next = PRESENT;
        end else begin
          state_next = SHORT;
        end
      end
      PRESENT: begin
        if (coin.coin_ready) begin
          state_next = SELECT;
        end
      end
      DONE:    state_next = IDLE;
      SHORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new request takes priority over refill; neither is looked at while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining    <= '0;
      coin_value_q <= '0;
      sel_q        <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        coin_count[i] <= INIT;
      end
    end else begin
      case (state)
        IDLE: begin
          if (change_valid) begin
            remaining <= change_value;
          end else if (refill) begin
            for (int i = 0; i < 4; i++) begin
              coin_count[i] <= INIT;
            end
          end
        end
        SELECT: begin
          if (remaining != '0 && pick_found) begin
            coin_value_q <= pick_value;
            sel_q        <= pick_idx;
          end
        end
        PRESENT: begin
          if (coin.coin_ready) begin
            remaining    <= remaining - coin_value_q;
            coin_value_q <= '0;
            if (coin_count[sel_q] != '0) begin
              coin_count[sel_q] <= coin_count[sel_q] - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign coin_count_0 = coin_count[0];
  assign coin_count_1 = coin_count[1];
  assign coin_count_2 = coin_count[2];
  assign coin_count_3 = coin_count[3];

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a greedy reference model queues the
// expected coins for each request and they are popped as the DUT ejects them.
module tb_change_dispenser;

  localparam int CW          = 7;
  localparam int COUNT_WIDTH = 4;
  localparam int INIT_COUNT  = 8;

  int denoms [4] = '{25, 10, 5, 1};

  logic                   clk = 1'b0;
  logic                   rst;
  logic [CW-1:0]          change_value;
  logic                   change_valid;
  logic                   refill;
  logic                   busy;
  logic                   change_done;
  logic                   change_short;
  logic [CW-1:0]          remaining;
  logic [COUNT_WIDTH-1:0] coin_count_0;
  logic [COUNT_WIDTH-1:0] coin_count_1;
  logic [COUNT_WIDTH-1:0] coin_count_2;
  logic [COUNT_WIDTH-1:0] coin_count_3;

  change_dispenser_if #(.CURRENCY_WIDTH(CW)) coin_if ();

  change_dispenser #(
    .CURRENCY_WIDTH (CW),
    .DENOM_0        (25),
    .DENOM_1        (10),
    .DENOM_2        (5),
    .DENOM_3        (1),
    .COUNT_WIDTH    (COUNT_WIDTH),
    .INIT_COUNT     (INIT_COUNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .change_value (change_value),
    .change_valid (change_valid),
    .refill       (refill),
    .coin         (coin_if),
    .busy         (busy),
    .change_done  (change_done),
    .change_short (change_short),
    .remaining    (remaining),
    .coin_count_0 (coin_count_0),
    .coin_count_1 (coin_count_1),
    .coin_count_2 (coin_count_2),
    .coin_count_3 (coin_count_3)
  );

  always #5 clk = ~clk;

  int exp_q [$];
  int model_cnt [4];
  int exp_rem;
  bit exp_short;
  int n_compared   = 0;
  int n_mismatched = 0;
  int last_coins;
  int last_done_cyc;
  int last_first_coin_cyc;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkCounts(input string tag, input int c0, input int c1, input int c2, input int c3);
    checkOutput({tag, "_cnt0"}, 32'(coin_count_0), c0);
    checkOutput({tag, "_cnt1"}, 32'(coin_count_1), c1);
    checkOutput({tag, "_cnt2"}, 32'(coin_count_2), c2);
    checkOutput({tag, "_cnt3"}, 32'(coin_count_3), c3);
  endtask

  task automatic modelRefill();
    for (int i = 0; i < 4; i++) model_cnt[i] = INIT_COUNT;
  endtask

  // Greedy reference: fills the scoreboard with the coins the DUT should eject.
  task automatic modelRequest(input int amount);
    int rem;
    int found;
    rem = amount;
    exp_q.delete();
    while (rem != 0) begin
      found = -1;
      for (int i = 0; i < 4; i++) begin
        if (found < 0 && denoms[i] <= rem && model_cnt[i] > 0) found = i;
      end
      if (found < 0) break;
      exp_q.push_back(denoms[found]);
      model_cnt[found]--;
      rem -= denoms[found];
    end
    exp_rem   = rem;
    exp_short = (rem != 0);
  endtask

  task automatic applyStimulus(input string tag, input int amount, input int stall,
                               input bit poke, input bit with_refill);
    int stall_left;
    bit finished;
    stall_left          = stall;
    finished            = 1'b0;
    last_coins          = 0;
    last_done_cyc       = -1;
    last_first_coin_cyc = -1;
    modelRequest(amount);
    @(negedge clk);
    change_value       = CW'(amount);
    change_valid       = 1'b1;
    refill             = with_refill;
    coin_if.coin_ready = (stall == 0);
    @(negedge clk);
    change_valid = 1'b0;
    refill       = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 1);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      change_valid = 1'b0;
      refill       = 1'b0;
      if (coin_if.coin_valid) begin
        if (last_first_coin_cyc < 0) last_first_coin_cyc = cyc;
        if (exp_q.size() == 0) begin
          coin_if.coin_ready = 1'b1;
          checkOutput({tag, "_extra_coin"}, 32'(coin_if.coin_valid), 0);
        end else if (stall_left > 0) begin
          coin_if.coin_ready = 1'b0;
          checkOutput({tag, "_stall_hold"}, 32'(coin_if.coin_value), exp_q[0]);
          stall_left--;
        end else begin
          coin_if.coin_ready = 1'b1;
          checkOutput({tag, "_coin"}, 32'(coin_if.coin_value), exp_q.pop_front());
          last_coins++;
          if (poke && last_coins == 1) begin
            change_value = CW'(99);
            change_valid = 1'b1;
            refill       = 1'b1;
          end
        end
      end
      if (change_done || change_short) begin
        last_done_cyc = cyc;
        checkOutput({tag, "_done"}, 32'(change_done), {31'd0, !exp_short});
        checkOutput({tag, "_short"}, 32'(change_short), {31'd0, exp_short});
        checkOutput({tag, "_rem"}, 32'(remaining), exp_rem);
        checkOutput({tag, "_coins_left"}, exp_q.size(), 0);
        finished = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_finished"}, {31'd0, finished}, 1);
    coin_if.coin_ready = 1'b1;
    checkOutput({tag, "_idle"}, 32'(busy), 0);
    checkOutput({tag, "_rem_hold"}, 32'(remaining), exp_rem);
    checkCounts(tag, model_cnt[0], model_cnt[1], model_cnt[2], model_cnt[3]);
  endtask

  initial begin
    rst                = 1'b1;
    change_value       = '0;
    change_valid       = 1'b0;
    refill             = 1'b0;
    coin_if.coin_ready = 1'b1;
    modelRefill();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_coin_valid", 32'(coin_if.coin_valid), 0);
    checkOutput("rst_coin_value", 32'(coin_if.coin_value), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(change_done), 0);
    checkOutput("rst_short", 32'(change_short), 0);
    checkOutput("rst_rem", 32'(remaining), 0);
    checkCounts("rst", 8, 8, 8, 8);

    applyStimulus("req37", 37, 0, 1'b0, 1'b0);
    checkCounts("req37_fixed", 7, 7, 8, 6);
    checkOutput("req37_ncoins", last_coins, 4);
    checkOutput("req37_first_coin_lat", last_first_coin_cyc, 1);

    applyStimulus("req30", 30, 5, 1'b0, 1'b0);
    checkOutput("req30_ncoins", last_coins, 2);
    checkCounts("req30_fixed", 6, 7, 7, 6);

    applyStimulus("req127", 127, 0, 1'b0, 1'b0);
    checkCounts("req127_fixed", 1, 7, 7, 4);
    checkOutput("req127_ncoins", last_coins, 7);

    while (model_cnt[3] > 0) applyStimulus("drain1", 1, 0, 1'b0, 1'b0);
    checkOutput("drain_cnt3", 32'(coin_count_3), 0);

    applyStimulus("short3", 3, 0, 1'b0, 1'b0);
    checkOutput("short3_rem", 32'(remaining), 3);
    checkOutput("short3_ncoins", last_coins, 0);

    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    modelRefill();
    checkCounts("refill_idle", 8, 8, 8, 8);

    applyStimulus("prep127", 127, 0, 1'b0, 1'b0);
    applyStimulus("prep75", 75, 0, 1'b0, 1'b0);
    applyStimulus("prep80", 80, 0, 1'b0, 1'b0);
    applyStimulus("prep40", 40, 0, 1'b0, 1'b0);
    applyStimulus("prep5", 5, 0, 1'b0, 1'b0);
    checkCounts("prep_fixed", 0, 0, 0, 1);
    applyStimulus("midshort", 2, 0, 1'b0, 1'b0);
    checkOutput("midshort_ncoins", last_coins, 1);
    checkOutput("midshort_rem", 32'(remaining), 1);

    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    modelRefill();
    applyStimulus("poke37", 37, 0, 1'b1, 1'b0);
    checkCounts("poke37_fixed", 7, 7, 8, 6);

    applyStimulus("zero", 0, 0, 1'b0, 1'b0);
    checkOutput("zero_ncoins", last_coins, 0);
    checkOutput("zero_done_lat", last_done_cyc, 1);

    applyStimulus("valid_beats_refill", 0, 0, 1'b0, 1'b1);
    checkCounts("valid_beats_refill_fixed", 7, 7, 8, 6);

    @(negedge clk);
    change_value       = CW'(30);
    change_valid       = 1'b1;
    coin_if.coin_ready = 1'b0;
    @(negedge clk);
    change_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_valid", 32'(coin_if.coin_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", 32'(coin_if.coin_valid), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_rem", 32'(remaining), 0);
    checkCounts("mid_rst", 8, 8, 8, 8);
    rst                = 1'b0;
    coin_if.coin_ready = 1'b1;
    exp_q.delete();
    modelRefill();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
